// File: rtl/rename_status_table_pkg.sv
// Shared constants for the rename status table and its neighbours.
// Widths of architectural and rename register identifiers live here.
package rename_status_table_pkg;

    localparam int REG_SEL  = 5;
    localparam int REG_NUM  = 32;
    localparam int RRF_SEL  = 6;
    localparam int DATA_LEN = 32;

    // Source lookups: rs1/rs2 of dispatch slot 1, then rs1/rs2 of slot 2.
    localparam int RD_PORTS = 4;

endpackage

// File: rtl/rename_status_table_if.sv
// Dispatch, commit and source-lookup bundle between the rename stage and
// the status table.
interface rename_status_table_if #(
    parameter int REG_SEL = rename_status_table_pkg::REG_SEL,
    parameter int RRF_SEL = rename_status_table_pkg::RRF_SEL
);
    import rename_status_table_pkg::*;

    logic               flush;
    logic               dp_stall;
    logic               dp_we1;
    logic               dp_we2;
    logic [REG_SEL-1:0] dp_reg1;
    logic [REG_SEL-1:0] dp_reg2;
    logic [RRF_SEL-1:0] dp_tag1;
    logic [RRF_SEL-1:0] dp_tag2;
    logic               com_en1;
    logic               com_en2;
    logic [REG_SEL-1:0] com_reg1;
    logic [REG_SEL-1:0] com_reg2;
    logic [RRF_SEL-1:0] com_tag1;
    logic [RRF_SEL-1:0] com_tag2;
    logic [REG_SEL-1:0] rd_reg  [RD_PORTS];
    logic               rd_busy [RD_PORTS];
    logic [RRF_SEL-1:0] rd_tag  [RD_PORTS];
    logic [REG_SEL:0]   busy_cnt;

    modport master (
        output flush, dp_stall,
        output dp_we1, dp_we2, dp_reg1, dp_reg2, dp_tag1, dp_tag2,
        output com_en1, com_en2, com_reg1, com_reg2, com_tag1, com_tag2,
        output rd_reg,
        input  rd_busy, rd_tag, busy_cnt
    );

    modport slave (
        input  flush, dp_stall,
        input  dp_we1, dp_we2, dp_reg1, dp_reg2, dp_tag1, dp_tag2,
        input  com_en1, com_en2, com_reg1, com_reg2, com_tag1, com_tag2,
        input  rd_reg,
        output rd_busy, rd_tag, busy_cnt
    );

endinterface

// File: rtl/rename_status_table.sv
// Architectural register rename status: per-register busy bit plus the RRF
// tag of the newest in-flight rename, with a running count of busy entries.
module rename_status_table #(
    parameter int REG_SEL = rename_status_table_pkg::REG_SEL,
    parameter int REG_NUM = rename_status_table_pkg::REG_NUM,
    parameter int RRF_SEL = rename_status_table_pkg::RRF_SEL
) (
    input logic               clk,
    input logic               reset_x,
    rename_status_table_if.slave bus
);
    import rename_status_table_pkg::*;

    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [RRF_SEL-1:0] tag_q [REG_NUM];
    logic [RRF_SEL-1:0] tag_d [REG_NUM];
    logic [REG_SEL:0]   busy_cnt_q;
    logic [REG_SEL:0]   busy_cnt_d;
    logic [REG_SEL:0]   n_set;
    logic [REG_SEL:0]   n_clr;

    logic dp_ok1;
    logic dp_ok2;
    logic com_ok1;
    logic com_ok2;

    assign dp_ok1  = bus.dp_we1 & ~bus.dp_stall & ~bus.flush;
    assign dp_ok2  = bus.dp_we2 & ~bus.dp_stall & ~bus.flush;
    assign com_ok1 = bus.com_en1 & ~bus.flush;
    assign com_ok2 = bus.com_en2 & ~bus.flush;

    // Register 0 is hardwired: never busy, tag always zero.
    assign busy_d[0] = 1'b0;
    assign tag_d[0]  = '0;

    // A dispatch beats any commit to the same entry; slot 2 beats slot 1.
    for (genvar i = 1; i < REG_NUM; i++) begin : g_entry
        localparam logic [REG_SEL-1:0] IDX = REG_SEL'(i);
        logic dp1;
        logic dp2;
        logic cm1;
        logic cm2;
        logic clr;

        assign dp1 = dp_ok1 & (bus.dp_reg1 == IDX);
        assign dp2 = dp_ok2 & (bus.dp_reg2 == IDX);
        assign cm1 = com_ok1 & (bus.com_reg1 == IDX) & (tag_q[i] == bus.com_tag1);
        assign cm2 = com_ok2 & (bus.com_reg2 == IDX) & (tag_q[i] == bus.com_tag2);
        assign clr = busy_q[i] & (cm1 | cm2);

        assign busy_d[i] = ~bus.flush & (dp1 | dp2 | (busy_q[i] & ~clr));
        assign tag_d[i]  = dp2 ? bus.dp_tag2 : (dp1 ? bus.dp_tag1 : tag_q[i]);
    end

    // Count only real 0->1 and 1->0 transitions so re-renames add nothing.
    always_comb begin
        n_set = '0;
        n_clr = '0;
        for (int i = 0; i < REG_NUM; i++) begin
            n_set = n_set + {{REG_SEL{1'b0}}, ~busy_q[i] &  busy_d[i]};
            n_clr = n_clr + {{REG_SEL{1'b0}},  busy_q[i] & ~busy_d[i]};
        end
        busy_cnt_d = busy_cnt_q + n_set - n_clr;
    end

    always_ff @(posedge clk) begin
        if (!reset_x) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            tag_q      <= tag_d;
        end
    end

    for (genvar k = 0; k < RD_PORTS; k++) begin : g_read
        assign bus.rd_busy[k] = busy_q[bus.rd_reg[k]];
        assign bus.rd_tag[k]  = tag_q[bus.rd_reg[k]];
    end

    assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: doc/rename_status_table.md
RENAME_STATUS_TABLE -- requirements
Module: rename_status_table

Interface
REQ-001 The block SHALL take these parameters, drawn from the shared constants file:
- REG_SEL, default 5, architectural register index width.
- REG_NUM, default 32, number of architectural registers.
- RRF_SEL, default 6, rename register file tag width.
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- reset_x  in  1  synchronous active-low reset.
- flush  in  1  misprediction recovery; discard all renames.
- dp_stall  in  1  blocks all dispatch writes.
- dp_we1, dp_we2  in  1  dispatch slot 1/2 writes a destination.
- dp_reg1, dp_reg2  in  REG_SEL  destination architectural register.
- dp_tag1, dp_tag2  in  RRF_SEL  allocated RRF tag.
- com_en1, com_en2  in  1  commit slot 1/2 retires a destination.
- com_reg1, com_reg2  in  REG_SEL  retired architectural register.
- com_tag1, com_tag2  in  RRF_SEL  retired RRF tag.
- rd_reg[0..3]  in  REG_SEL  source lookups: rs1/rs2 of slot 1, rs1/rs2 of slot 2.
- rd_busy[0..3]  out  1  arf_busy toward the source operand managers.
- rd_tag[0..3]  out  RRF_SEL  rrftag toward the source operand managers.
- busy_cnt  out  REG_SEL+1  number of busy entries.

Function
REQ-004 Each table entry SHALL hold a busy bit and an RRF_SEL-bit tag.
REQ-005 Entry 0 SHALL never be busy. Writes to register 0 SHALL be ignored, and reads of register 0 SHALL return busy=0 and tag=0.
REQ-006 Lookups SHALL be combinational from registered state:
- The read returns the state before this cycle's updates (no write-to-read bypass).
- Intra-group dependences are resolved downstream by src_eq_dst1.
REQ-007 An effective dispatch (dp_weN & ~dp_stall & ~flush, dp_regN≠0) SHALL take effect at the next clock edge: busy is set to 1 and tag to dp_tagN.
REQ-008 If both dispatch slots name the same register, slot 2 SHALL win (tag = dp_tag2).
REQ-009 An effective commit (com_enN & ~flush) SHALL clear busy only when the entry is busy and its stored tag equals com_tagN. Otherwise it SHALL have no effect, because a newer rename is outstanding.
REQ-010 When a dispatch and a commit hit the same register in one cycle, the dispatch SHALL win: busy stays 1 and the tag is updated.
REQ-011 When both commit slots hit the same register, the register SHALL clear if either commit's tag matches.
REQ-012 Asserting flush SHALL clear every busy bit at the next edge. Tags are not cleared, and flush SHALL take precedence over all dispatch and commit inputs.
REQ-013 busy_cnt SHALL be a registered count that equals the population count of the busy bits at all times.
- It is updated incrementally each cycle: +(new sets) −(new clears), with no double counting.
- Range 0..REG_NUM−1; it SHALL never wrap.
REQ-014 A dispatch that re-renames an already-busy register SHALL NOT increment busy_cnt.

Reset
REQ-015 While reset_x=0 at a clock edge, every busy bit, every tag and busy_cnt SHALL become 0.
REQ-016 Reset SHALL override flush, dispatch and commit. Outputs SHALL read busy=0, tag=0 from the first cycle after reset.
REQ-017 Deasserting reset mid-stream SHALL require no recovery cycles; dispatch is accepted in the first cycle with reset_x=1.

Structure
REQ-018 REG_SEL, REG_NUM, RRF_SEL and DATA_LEN SHALL come from the shared constants include. No new shared constants SHALL be added.
REQ-019 The block SHALL be a single module with no sub-modules; the per-entry next-state logic is a generate loop.
REQ-020 Outputs SHALL connect directly to the arf_busy/rrftag inputs of the four source operand managers, with no added pipeline stage.

Verification
REQ-021 Reset, then dispatch r5 with tag 12 -> next cycle rd_busy=1, rd_tag=12, busy_cnt=1. Then commit r5 with tag 12 -> busy=0, busy_cnt=0.
REQ-022 Dispatch r7 with tag 3 (slot 1) and r7 with tag 9 (slot 2) in the same cycle -> tag=9, busy_cnt=1. Then commit r7 with tag 3 -> r7 stays busy.
REQ-023 r4 busy with tag 20; in the same cycle, commit r4 tag 20 and dispatch r4 tag 21 -> busy=1, tag=21, busy_cnt unchanged.
REQ-024 Dispatch r0 with tag 5, and separately dispatch with dp_stall=1 -> no state change and busy_cnt=0. A lookup of r0 reads busy=0, tag=0.
REQ-025 Fill r1..r31 busy -> busy_cnt=31. Then flush together with a dispatch of r2 -> all busy=0, busy_cnt=0.
REQ-026 Hold reset_x=0 during an active dispatch and commit -> all outputs read 0 the next cycle. Release reset -> a dispatch in the first cycle is accepted.
